apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin APB master that lets several on-chip requesters (host register path, LSTM sequencer, weight loader) share the single APB bus into `apb_slave`. It accepts simple request/done transactions on each requester port and drives one APB transfer at a time through the full SETUP/ACCESS protocol. It honours wait states (PREADY) and returns PRDATA/PSLVERR to the owning requester.

## Interface
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 32, APB data width
- NUM_REQ, 2, number of requesters (≥2)
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with timeout feature)

- PCLK  in  1  clock; all logic rising-edge
- PRESET  in  1  reset, asynchronous, active-high
- req_i  in  NUM_REQ  per-requester transfer request, level
- req_we_i  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- req_done_o  out  NUM_REQ  one-hot completion pulse, 1 cycle
- rsp_rdata_o  out  DATA_WIDTH  read data, valid while any req_done_o high
- rsp_err_o  out  1  error flag, valid while any req_done_o high
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- Requester handshake: raise req_i[k] with stable we/addr/wdata; hold until req_done_o[k]; may deassert or present a new transfer in the cycle after done.
- FSM states IDLE, SETUP, ACCESS.
  - IDLE: if any eligible request, latch winner index, PADDR/PWRITE/PWDATA from winner → SETUP.
  - SETUP: PSEL=1, PENABLE=0, one cycle → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0; on PREADY=1 capture PRDATA (reads; writes return 0) and PSLVERR, pulse req_done_o[winner] next cycle, → IDLE.
- Eligibility: a requester whose req_done_o is high this cycle is excluded from arbitration (prevents re-grant of a stale request).
- Round-robin: priority starts at last_grant+1 modulo NUM_REQ. Reset last_grant=NUM_REQ-1, so requester 0 wins first.
- Bus fields latched at grant; requester changes after grant are ignored.
- PADDR/PWDATA/PWRITE hold last values in IDLE; PSEL=PENABLE=0 in IDLE.
- Reset mid-transfer: outputs drop immediately, no done issued, transfer abandoned.

## Timing
- Reset values: PSEL, PENABLE, PWRITE 0; PADDR, PWDATA 0; req_done_o 0; rsp_rdata_o 0; rsp_err_o 0; state IDLE; last_grant NUM_REQ-1.
- Request sampled at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2.
- Zero-wait transfer: done in cycle N+3 (4 cycles req→done); each wait state adds one.
- Back-to-back: min 4 cycles per transfer (IDLE during done cycle, then SETUP).
- Simultaneous requests in IDLE: exactly one granted per round-robin; others wait, never starve (bounded by NUM_REQ transfers).

## Configuration
- APB_ARB_TIMEOUT_EN defined: cycle counter in ACCESS, cleared on entry. After TIMEOUT_CYCLES consecutive cycles with PREADY=0, abort: PSEL/PENABLE drop, done pulses with rsp_err_o=1, rsp_rdata_o=0, → IDLE.
- Not defined: ACCESS waits indefinitely for PREADY; no counter logic.

## Structure
- Package apb_arb_pkg: state enum typedef (IDLE/SETUP/ACCESS), default width constants, rsp struct (rdata, err).
- Sub-module rr_arbiter: combinational round-robin picker; inputs masked request vector and last_grant; outputs one-hot grant and index, valid flag.

## Test plan
- Single write: req 0 writes 0xDEADBEEF @0x10 → PSEL 1 cycle SETUP, 1 cycle ACCESS, req_done_o=2'b01 at cycle 4, rsp_err_o=0.
- Read-back: req 1 reads @0x10 → rsp_rdata_o=0xDEADBEEF with req_done_o=2'b10.
- Contention: both request in same cycle (0 writes 0xCAFEBABE @0x20, 1 reads @0x20) → requester 0 served first, requester 1 gets 0xCAFEBABE; then both again → requester 1 first.
- Wait states: slave holds PREADY low 3 cycles → PENABLE high 4 cycles, done at cycle 7, fields stable throughout.
- Slave error: PSLVERR=1 with PREADY → rsp_err_o=1 with done; with APB_ARB_TIMEOUT_EN and PREADY stuck low, done with err=1 after 16 ACCESS cycles.
- Reset mid-ACCESS: PRESET pulse → PSEL/PENABLE 0 immediately, no done; next request after release served normally starting from requester 0.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// apb_arb_pkg: shared state encoding, default widths and response payload
// for the round-robin APB master arbiter.
package apb_arb_pkg;

  localparam int unsigned ARB_ADDR_W  = 8;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_NUM_REQ = 2;
  localparam int unsigned ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ARB_DATA_W-1:0] rdata;
    logic                  err;
  } arb_rsp_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side handshake plus APB bus, bundled for the arbiter.
// master: the arbiter's view; slave: the requesters + APB slave view.
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_W,
  parameter int unsigned DATA_WIDTH = ARB_DATA_W,
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ
) ();

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            req_done_o;
  logic [DATA_WIDTH-1:0]         rsp_rdata_o;
  logic                          rsp_err_o;

  logic                          PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PREADY;
  logic                          PSLVERR;

  modport master (
    input  req_i, req_we_i, req_addr_i, req_wdata_i,
    output req_done_o, rsp_rdata_o, rsp_err_o,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_done_o, rsp_rdata_o, rsp_err_o,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Search starts one past
// last_grant and wraps, so the most recent winner has lowest priority.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               valid_c
);

  int unsigned cand;

  // First requester found walking forward from last_grant+1 wins
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + i) % NUM_REQ;
      if (!valid_c && req[IDX_W'(cand)]) begin
        grant_c[IDX_W'(cand)] = 1'b1;
        idx_c                 = IDX_W'(cand);
        valid_c               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NUM_REQ requesters
// with round-robin arbitration and full SETUP/ACCESS sequencing.
// Optional feature macro: APB_ARB_TIMEOUT_EN (aborts ACCESS after
// TIMEOUT_CYCLES cycles without PREADY, completing with an error).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ARB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = ARB_DATA_W,
  parameter int unsigned NUM_REQ        = ARB_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'(ARB_IDLE);
  localparam logic [1:0] S_SETUP  = 2'(ARB_SETUP);
  localparam logic [1:0] S_ACCESS = 2'(ARB_ACCESS);

  logic [1:0]            state_q,   state_d;
  logic [IDX_W-1:0]      last_q,    last_d;
  logic [NUM_REQ-1:0]    owner_q,   owner_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic [NUM_REQ-1:0]    done_q,    done_d;
  arb_rsp_t              rsp_q,     rsp_d;

  logic [NUM_REQ-1:0]    elig_c;
  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      grant_idx_c;
  logic                  grant_valid_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  sel_we_c;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

  // A requester being acknowledged this cycle still shows its old request
  assign elig_c = bus.req_i & ~done_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (elig_c),
    .last_grant (last_q),
    .grant_c    (grant_c),
    .idx_c      (grant_idx_c),
    .valid_c    (grant_valid_c)
  );

  // Mux the winner's transfer fields out of the packed request buses
  always_comb begin
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_we_c    = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant_c[k]) begin
        sel_addr_c  = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = bus.req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_we_c    = bus.req_we_i[k];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    rsp_d     = rsp_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_valid_c) begin
          state_d  = S_SETUP;
          last_d   = grant_idx_c;
          owner_d  = grant_c;
          psel_d   = 1'b1;
          pwrite_d = sel_we_c;
          paddr_d  = sel_addr_c;
          pwdata_d = sel_wdata_c;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          state_d    = S_IDLE;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          done_d     = owner_q;
          rsp_d.rdata = pwrite_q ? '0 : ARB_DATA_W'(bus.PRDATA);
          rsp_d.err   = bus.PSLVERR;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          done_d      = owner_q;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rsp_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rsp_q     <= rsp_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.req_done_o  = done_q;
  assign bus.rsp_rdata_o = DATA_WIDTH'(rsp_q.rdata);
  assign bus.rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers push their
// expected completion; a monitor pops and compares on every req_done_o.
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  apb_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    logic          idx;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] mem [256];
  int            wait_cfg = 0;
  logic [AW-1:0] err_addr = 8'hEE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic idx, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k) begin
      bus.req_addr_i[AW +: AW]  = a;
      bus.req_wdata_i[DW +: DW] = d;
    end else begin
      bus.req_addr_i[0 +: AW]   = a;
      bus.req_wdata_i[0 +: DW]  = d;
    end
    bus.req_we_i[k] = we;
    bus.req_i[k]    = 1'b1;
  endtask

  // One cycle; requesters drop their request once acknowledged
  task automatic step();
    @(negedge clk);
    bus.req_i = bus.req_i & ~bus.req_done_o;
  endtask

  task automatic wait_clear(input string name, input int budget);
    int n = 0;
    while (bus.req_i != '0 && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    if (bus.req_i != '0) begin
      n_err++;
      $display("FAIL %s_timeout: req_i still 0x%0h after %0d cycles, expected 0", name, bus.req_i, budget);
      bus.req_i = '0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_done_o != '0) begin
        chk("done_onehot", 64'($onehot(bus.req_done_o)), 64'd1);
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=0x%0h, expected no completion", bus.req_done_o);
        end else begin
          e = sb.pop_front();
          chk("done_owner", 64'(bus.req_done_o), e.idx ? 64'h2 : 64'h1);
          chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
        end
      end
    end
  endtask

  // APB slave: wait_cfg wait states, PSLVERR at err_addr, writes land on the ready cycle
  task automatic slave();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !(bus.PSEL && bus.PENABLE)) begin
        cnt = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end else if (cnt < wait_cfg) begin
        cnt++;
        bus.PREADY = 1'b0;
      end else begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = mem[bus.PADDR];
        bus.PSLVERR = (bus.PADDR == err_addr);
        if (bus.PWRITE && bus.PADDR != err_addr) mem[bus.PADDR] = bus.PWDATA;
      end
    end
  endtask

  initial begin
    int en_cnt;
    int acc;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'hEE] = 32'hA5A5A5A5;
    bus.req_i = '0; bus.req_we_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;

    fork
      monitor();
      slave();
      begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
      end
    join_none

    // Reset values
    step(); step(); step();
    chk("rst_psel",    64'(bus.PSEL),        64'd0);
    chk("rst_penable", 64'(bus.PENABLE),     64'd0);
    chk("rst_pwrite",  64'(bus.PWRITE),      64'd0);
    chk("rst_paddr",   64'(bus.PADDR),       64'd0);
    chk("rst_pwdata",  64'(bus.PWDATA),      64'd0);
    chk("rst_done",    64'(bus.req_done_o),  64'd0);
    chk("rst_rdata",   64'(bus.rsp_rdata_o), 64'd0);
    chk("rst_err",     64'(bus.rsp_err_o),   64'd0);
    rst = 1'b0;

    // Single write by requester 0, cycle-accurate phase checks
    set_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    push_exp(1'b0, 32'h0, 1'b0);
    step();
    chk("t1_setup_psel",    64'(bus.PSEL),    64'd1);
    chk("t1_setup_penable", 64'(bus.PENABLE), 64'd0);
    chk("t1_paddr",         64'(bus.PADDR),   64'h10);
    chk("t1_pwrite",        64'(bus.PWRITE),  64'd1);
    chk("t1_pwdata",        64'(bus.PWDATA),  64'hDEADBEEF);
    step();
    chk("t1_access_psel",    64'(bus.PSEL),    64'd1);
    chk("t1_access_penable", 64'(bus.PENABLE), 64'd1);
    step();
    chk("t1_done_cycle4", 64'(bus.req_done_o), 64'h1);
    chk("t1_idle_psel",   64'(bus.PSEL),       64'd0);
    chk("t1_idle_paddr_hold", 64'(bus.PADDR),  64'h10);
    wait_clear("t1", 4);

    // Read-back by requester 1
    set_req(1'b1, 1'b0, 8'h10, 32'h0);
    push_exp(1'b1, 32'hDEADBEEF, 1'b0);
    wait_clear("t2", 10);

    // Contention after requester 1: requester 0 goes first
    set_req(1'b0, 1'b1, 8'h20, 32'hCAFEBABE);
    set_req(1'b1, 1'b0, 8'h20, 32'h0);
    push_exp(1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 32'hCAFEBABE, 1'b0);
    step();
    chk("t3_first_is_write", 64'(bus.PWRITE), 64'd1);
    wait_clear("t3", 20);

    set_req(1'b0, 1'b0, 8'h20, 32'h0);
    push_exp(1'b0, 32'hCAFEBABE, 1'b0);
    wait_clear("t3b", 10);

    // Contention after requester 0: requester 1 goes first
    set_req(1'b0, 1'b1, 8'h30, 32'h11111111);
    set_req(1'b1, 1'b0, 8'h30, 32'h0);
    push_exp(1'b1, 32'h0, 1'b0);
    push_exp(1'b0, 32'h0, 1'b0);
    step();
    chk("t3c_first_is_read", 64'(bus.PWRITE), 64'd0);
    wait_clear("t3c", 20);

    set_req(1'b1, 1'b0, 8'h30, 32'h0);
    push_exp(1'b1, 32'h11111111, 1'b0);
    wait_clear("t3d", 10);

    // Three wait states; requester fields changed after grant must not leak
    wait_cfg = 3;
    set_req(1'b0, 1'b1, 8'h40, 32'h12345678);
    push_exp(1'b0, 32'h0, 1'b0);
    step();
    chk("t4_setup_penable", 64'(bus.PENABLE), 64'd0);
    bus.req_addr_i[0 +: AW]  = 8'hFF;
    bus.req_wdata_i[0 +: DW] = 32'h0;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.PSEL && bus.PENABLE) en_cnt++;
      chk("t4_paddr_stable",  64'(bus.PADDR),  64'h40);
      chk("t4_pwdata_stable", 64'(bus.PWDATA), 64'h12345678);
    end
    chk("t4_penable_cycles", 64'(en_cnt), 64'd4);
    step();
    chk("t4_done_cycle7", 64'(bus.req_done_o), 64'h1);
    wait_cfg = 0;
    wait_clear("t4", 4);

    set_req(1'b1, 1'b0, 8'h40, 32'h0);
    push_exp(1'b1, 32'h12345678, 1'b0);
    wait_clear("t4b", 10);

    // Slave error on read and on write
    set_req(1'b1, 1'b0, 8'hEE, 32'h0);
    push_exp(1'b1, 32'hA5A5A5A5, 1'b1);
    wait_clear("t5a", 10);
    set_req(1'b0, 1'b1, 8'hEE, 32'h55AA55AA);
    push_exp(1'b0, 32'h0, 1'b1);
    wait_clear("t5b", 10);

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck slave: abort after 16 ACCESS cycles with an error
    wait_cfg = 1000;
    set_req(1'b1, 1'b0, 8'h50, 32'h0);
    push_exp(1'b1, 32'h0, 1'b1);
    acc = 0;
    for (int i = 0; i < 40 && bus.req_done_o == '0; i++) begin
      step();
      if (bus.PENABLE) acc++;
    end
    chk("t5c_access_cycles", 64'(acc), 64'd16);
    wait_cfg = 0;
    wait_clear("t5c", 4);
`else
    acc = 0;
`endif

    // Reset during ACCESS abandons the transfer; arbitration restarts at 0
    wait_cfg = 5;
    set_req(1'b1, 1'b0, 8'h10, 32'h0);
    step();
    step();
    chk("t6_in_access", 64'(bus.PENABLE), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_psel",    64'(bus.PSEL),    64'd0);
    chk("t6_rst_penable", 64'(bus.PENABLE), 64'd0);
    bus.req_i = '0;
    step();
    step();
    chk("t6_no_done", 64'(bus.req_done_o), 64'd0);
    rst = 1'b0;
    wait_cfg = 0;
    set_req(1'b0, 1'b0, 8'h10, 32'h0);
    set_req(1'b1, 1'b0, 8'h20, 32'h0);
    push_exp(1'b0, 32'hDEADBEEF, 1'b0);
    push_exp(1'b1, 32'hCAFEBABE, 1'b0);
    wait_clear("t6", 20);

    step();
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
